// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and defaults for the round-robin Wishbone arbiter
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_t;

    localparam int DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/wb_arb_rr_pick.sv
// rtl/wb_arb_rr_pick.sv - combinational round-robin requester search
// Ports: req_i   request vector, one bit per master
//        last_i  index of the most recently released owner
//        gnt_o   one-hot next owner (all zero when nobody requests)
module wb_arb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int NM = 2,
    parameter int LW = (NM > 1) ? $clog2(NM) : 1
) (
    input  logic [NM-1:0] req_i,
    input  logic [LW-1:0] last_i,
    output logic [NM-1:0] gnt_o
);

    logic          found;
    logic [LW-1:0] idx;

    // Walk last+1, last+2, ... wrapping at NM; the previous owner is checked
    // last so it only wins again when nobody else is asking.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NM; i++) begin
            idx = LW'((int'(last_i) + i) % NM);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter_rr.sv
// rtl/wb_arbiter_rr.sv - round-robin N-master to 1-slave Wishbone arbiter with stall watchdog
// Ports: i_clk, i_reset (async, active-high)
//        m_*_i / m_ack_o, m_err_o, m_data_o  master-side bus (packed per master)
//        s_*_o / s_ack_i, s_err_i, s_data_i  slave-side bus
//        o_grant  one-hot current owner, o_busy  any owner active
module wb_arbiter_rr
    import wb_arb_pkg::*;
#(
    parameter int NM      = 2,
    parameter int AW      = 26,
    parameter int DW      = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NM-1:0]        m_cyc_i,
    input  logic [NM-1:0]        m_stb_i,
    input  logic [NM-1:0]        m_we_i,
    input  logic [NM*AW-1:0]     m_adr_i,
    input  logic [NM*DW-1:0]     m_data_i,
    input  logic [NM*DW/8-1:0]   m_sel_i,
    input  logic [NM*3-1:0]      m_cti_i,
    input  logic [NM*2-1:0]      m_bte_i,
    output logic [NM-1:0]        m_ack_o,
    output logic [NM-1:0]        m_err_o,
    output logic [DW-1:0]        m_data_o,
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    output logic                 s_we_o,
    output logic [AW-1:0]        s_adr_o,
    output logic [DW-1:0]        s_data_o,
    output logic [DW/8-1:0]      s_sel_o,
    output logic [2:0]           s_cti_o,
    output logic [1:0]           s_bte_o,
    input  logic                 s_ack_i,
    input  logic                 s_err_i,
    input  logic [DW-1:0]        s_data_i,
    output logic [NM-1:0]        o_grant,
    output logic                 o_busy
);

    localparam int            LW   = (NM > 1) ? $clog2(NM) : 1;
    localparam int            CW   = $clog2(TIMEOUT + 1);
    localparam int            SW   = DW / 8;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

    arb_state_t    state_q, state_d;
    logic [NM-1:0] grant_q, grant_d;
    logic [LW-1:0] last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [NM-1:0] pick;
    logic [LW-1:0] gidx;
    logic          stalled;
    logic          timeout_hit;
    logic          resp_ok;

    wb_arb_rr_pick #(.NM(NM), .LW(LW)) u_pick (
        .req_i  (m_cyc_i),
        .last_i (last_q),
        .gnt_o  (pick)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NM; i++) begin
            if (grant_q[i]) gidx = LW'(i);
        end
    end

    // Slave-side mux; cyc/stb only pass through in GRANT so ABORT and IDLE
    // present an idle bus.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_data_o = '0;
        s_sel_o  = '0;
        s_cti_o  = '0;
        s_bte_o  = '0;
        if (|grant_q) begin
            s_we_o   = m_we_i[gidx];
            s_adr_o  = m_adr_i[gidx*AW +: AW];
            s_data_o = m_data_i[gidx*DW +: DW];
            s_sel_o  = m_sel_i[gidx*SW +: SW];
            s_cti_o  = m_cti_i[gidx*3 +: 3];
            s_bte_o  = m_bte_i[gidx*2 +: 2];
            if (state_q == ST_GRANT) begin
                s_cyc_o = m_cyc_i[gidx];
                s_stb_o = m_cyc_i[gidx] & m_stb_i[gidx];
            end
        end
    end

    assign stalled     = (state_q == ST_GRANT) && s_stb_o && !s_ack_i && !s_err_i;
    // A slave response in the final cycle clears stalled, so it beats the abort.
    assign timeout_hit = stalled && (cnt_q == TMAX);
    // Responses only reach an owner still holding cyc; late acks after a
    // release are dropped.
    assign resp_ok     = (state_q == ST_GRANT) && m_cyc_i[gidx];

    assign m_ack_o  = (resp_ok && s_ack_i) ? grant_q : '0;
    assign m_err_o  = (resp_ok && (s_err_i || timeout_hit)) ? grant_q : '0;
    assign m_data_o = s_data_i;
    assign o_grant  = grant_q;
    assign o_busy   = |grant_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (|m_cyc_i) begin
                    grant_d = pick;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!m_cyc_i[gidx]) begin
                    grant_d = '0;
                    last_d  = gidx;
                    state_d = ST_IDLE;
                end else if (timeout_hit) begin
                    state_d = ST_ABORT;
                end else if (stalled) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ABORT: begin
                if (!m_cyc_i[gidx]) begin
                    grant_d = '0;
                    last_d  = gidx;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= LW'(NM - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// tb/tb_wb_arbiter_rr.sv - directed self-checking bench for wb_arbiter_rr
module tb_wb_arbiter_rr;

    localparam int NM = 2;
    localparam int AW = 26;
    localparam int DW = 32;
    localparam int TO = 8;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic [NM-1:0]     m_cyc_i, m_stb_i, m_we_i;
    logic [NM*AW-1:0]  m_adr_i;
    logic [NM*DW-1:0]  m_data_i;
    logic [NM*DW/8-1:0] m_sel_i;
    logic [NM*3-1:0]   m_cti_i;
    logic [NM*2-1:0]   m_bte_i;
    logic [NM-1:0]     m_ack_o, m_err_o;
    logic [DW-1:0]     m_data_o;
    logic              s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_data_o;
    logic [DW/8-1:0]   s_sel_o;
    logic [2:0]        s_cti_o;
    logic [1:0]        s_bte_o;
    logic              s_ack_i, s_err_i;
    logic [DW-1:0]     s_data_i;
    logic [NM-1:0]     o_grant;
    logic              o_busy;

    int n_assert = 0;
    int n_fail   = 0;
    int order [4] = '{0, 1, 0, 1};

    wb_arbiter_rr #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .m_cyc_i  (m_cyc_i),
        .m_stb_i  (m_stb_i),
        .m_we_i   (m_we_i),
        .m_adr_i  (m_adr_i),
        .m_data_i (m_data_i),
        .m_sel_i  (m_sel_i),
        .m_cti_i  (m_cti_i),
        .m_bte_i  (m_bte_i),
        .m_ack_o  (m_ack_o),
        .m_err_o  (m_err_o),
        .m_data_o (m_data_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_we_o   (s_we_o),
        .s_adr_o  (s_adr_o),
        .s_data_o (s_data_o),
        .s_sel_o  (s_sel_o),
        .s_cti_o  (s_cti_o),
        .s_bte_o  (s_bte_o),
        .s_ack_i  (s_ack_i),
        .s_err_i  (s_err_i),
        .s_data_i (s_data_i),
        .o_grant  (o_grant),
        .o_busy   (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_masters();
        m_cyc_i  = '0;
        m_stb_i  = '0;
        m_we_i   = '0;
        m_adr_i  = {26'h2bbb, 26'h1aaa};
        m_data_i = {32'h3333_4444, 32'h1111_2222};
        m_sel_i  = 8'hff;
        m_cti_i  = '0;
        m_bte_i  = '0;
        s_ack_i  = 1'b0;
        s_err_i  = 1'b0;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        #1;
    endtask

    initial begin
        clear_masters();
        s_data_i = 32'h0000_5a5a;
        i_reset  = 1'b1;
        #3;
        chk("rst_grant", o_grant, 2'b00);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_scyc", s_cyc_o, 1'b0);
        chk("rst_sstb", s_stb_o, 1'b0);
        chk("rst_ack", m_ack_o, 2'b00);
        chk("rst_err", m_err_o, 2'b00);
        chk("rst_rdata", m_data_o, 32'h0000_5a5a);
        step();
        step();
        i_reset = 1'b0;
        #1;

        // Master 0 alone: single read, slave acks 3 cycles after stb
        m_cyc_i = 2'b01;
        m_stb_i = 2'b01;
        #1;
        chk("a_idle_scyc", s_cyc_o, 1'b0);
        chk("a_idle_sadr", s_adr_o, 26'h0);
        step(); #1;
        chk("a_grant", o_grant, 2'b01);
        chk("a_scyc", s_cyc_o, 1'b1);
        chk("a_sadr", s_adr_o, 26'h1aaa);
        chk("a_sdata", s_data_o, 32'h1111_2222);
        chk("a_busy", o_busy, 1'b1);
        step(); #1;
        chk("a_wait1_ack", m_ack_o, 2'b00);
        step(); #1;
        chk("a_wait2_ack", m_ack_o, 2'b00);
        step();
        s_ack_i  = 1'b1;
        s_data_i = 32'hdead_beef;
        #1;
        chk("a_ack", m_ack_o, 2'b01);
        chk("a_rdata", m_data_o, 32'hdead_beef);
        step();
        s_ack_i = 1'b0;
        m_cyc_i = 2'b00;
        m_stb_i = 2'b00;
        #1;
        chk("a_ack_single", m_ack_o, 2'b00);
        chk("a_rel_scyc", s_cyc_o, 1'b0);
        step(); #1;
        chk("a_idle_grant", o_grant, 2'b00);

        // Both masters request continuously: 0,1,0,1 with one idle cycle between
        do_reset();
        m_cyc_i = 2'b11;
        m_stb_i = 2'b11;
        #1;
        chk("b_idle_grant", o_grant, 2'b00);
        for (int k = 0; k < 4; k++) begin
            step(); #1;
            chk($sformatf("b_grant%0d", k), o_grant, (order[k] == 0) ? 2'b01 : 2'b10);
            chk($sformatf("b_sadr%0d", k), s_adr_o, (order[k] == 0) ? 26'h1aaa : 26'h2bbb);
            s_ack_i = 1'b1;
            #1;
            chk($sformatf("b_ack%0d", k), m_ack_o, (order[k] == 0) ? 2'b01 : 2'b10);
            step();
            s_ack_i = 1'b0;
            m_cyc_i[order[k]] = 1'b0;
            m_stb_i[order[k]] = 1'b0;
            #1;
            chk($sformatf("b_rel_scyc%0d", k), s_cyc_o, 1'b0);
            step();
            m_cyc_i[order[k]] = 1'b1;
            m_stb_i[order[k]] = 1'b1;
            #1;
            chk($sformatf("b_gap%0d", k), o_grant, 2'b00);
        end
        clear_masters();
        step();
        step();

        // Slave never acks: error on the 8th stalled cycle, then ABORT
        do_reset();
        m_cyc_i = 2'b01;
        m_stb_i = 2'b01;
        #1;
        for (int s = 1; s <= TO; s++) begin
            step(); #1;
            chk($sformatf("c_scyc%0d", s), s_cyc_o, 1'b1);
            chk($sformatf("c_err%0d", s), m_err_o, (s == TO) ? 2'b01 : 2'b00);
        end
        step(); #1;
        chk("c_abort_scyc", s_cyc_o, 1'b0);
        chk("c_abort_err", m_err_o, 2'b00);
        chk("c_abort_grant", o_grant, 2'b01);
        step(); #1;
        chk("c_abort_scyc2", s_cyc_o, 1'b0);
        m_cyc_i = 2'b00;
        m_stb_i = 2'b00;
        #1;
        step(); #1;
        chk("c_idle_grant", o_grant, 2'b00);
        chk("c_idle_busy", o_busy, 1'b0);

        // Ack on the 8th stalled cycle wins over the abort
        do_reset();
        m_cyc_i = 2'b01;
        m_stb_i = 2'b01;
        #1;
        for (int s = 1; s <= TO; s++) begin
            step();
            if (s == TO) s_ack_i = 1'b1;
            #1;
            chk($sformatf("d_err%0d", s), m_err_o, 2'b00);
            chk($sformatf("d_ack%0d", s), m_ack_o, (s == TO) ? 2'b01 : 2'b00);
        end
        step();
        s_ack_i = 1'b0;
        #1;
        chk("d_noabort_scyc", s_cyc_o, 1'b1);
        chk("d_restall1_err", m_err_o, 2'b00);
        for (int s = 2; s < TO; s++) begin
            step(); #1;
            chk($sformatf("d_restall%0d_err", s), m_err_o, 2'b00);
        end
        step(); #1;
        chk("d_restall8_err", m_err_o, 2'b01);
        step();
        m_cyc_i = 2'b00;
        m_stb_i = 2'b00;
        step(); #1;
        chk("d_idle_grant", o_grant, 2'b00);

        // Asynchronous reset while master 1 owns the bus with stb pending
        do_reset();
        m_cyc_i = 2'b10;
        m_stb_i = 2'b10;
        m_we_i  = 2'b10;
        #1;
        step(); #1;
        chk("e_grant", o_grant, 2'b10);
        chk("e_swe", s_we_o, 1'b1);
        chk("e_sadr", s_adr_o, 26'h2bbb);
        step();
        #3;
        i_reset = 1'b1;
        #1;
        chk("e_rst_scyc", s_cyc_o, 1'b0);
        chk("e_rst_grant", o_grant, 2'b00);
        chk("e_rst_busy", o_busy, 1'b0);
        m_cyc_i = 2'b11;
        m_stb_i = 2'b11;
        step();
        i_reset = 1'b0;
        #1;
        chk("e_idle_grant", o_grant, 2'b00);
        step(); #1;
        chk("e_first_grant", o_grant, 2'b01);

        clear_masters();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter_rr.md
WB_ARBITER_RR -- requirements
Module: wb_arbiter_rr

Interface
REQ-001 Parameters SHALL be: NM, default 2, number of Wishbone masters; AW, default 26, address width; DW, default 32, data width; TIMEOUT, default 1024, stall cycles before abort.
REQ-002 Ports SHALL be, clock and reset first:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous active-high reset.
- m_cyc_i, m_stb_i, m_we_i  in  NM each  per-master Wishbone cycle, strobe and write enable.
- m_adr_i  in  NM*AW  per-master address.
- m_data_i  in  NM*DW  per-master write data.
- m_sel_i  in  NM*DW/8  per-master byte select.
- m_cti_i  in  NM*3  per-master cycle type.
- m_bte_i  in  NM*2  per-master burst type.
- m_ack_o, m_err_o  out  NM each  per-master acknowledge and error.
- m_data_o  out  DW  read data, broadcast to all masters.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave cycle, strobe and write enable.
- s_adr_o  out  AW  slave address.
- s_data_o  out  DW  slave write data.
- s_sel_o  out  DW/8  slave byte select.
- s_cti_o  out  3  slave cycle type.
- s_bte_o  out  2  slave burst type.
- s_ack_i, s_err_i, s_data_i  in  1/1/DW  slave acknowledge, error and read data.
- o_grant  out  NM  one-hot current grant.
- o_busy  out  1  any grant active.
REQ-003 Reset SHALL be i_reset, asynchronous, active-high; clock SHALL be i_clk.

Function
REQ-004 The FSM SHALL have three states: IDLE, GRANT and ABORT.
REQ-005 In IDLE with any m_cyc_i high, the arbiter SHALL register a one-hot grant to the first requester searching round-robin from last_grant+1 modulo NM, then enter GRANT on the next edge (1-cycle arbitration latency).
REQ-006 In GRANT, all s_* outputs SHALL be a combinational mux of the granted master's signals.
REQ-007 Whenever no grant is active, s_cyc_o and s_stb_o SHALL be 0 and the s_* data/address outputs SHALL be 0.
REQ-008 s_ack_i and s_err_i SHALL route only to the granted master; m_ack_o and m_err_o of non-granted masters SHALL be 0.
REQ-009 m_data_o SHALL equal s_data_i at all times.
REQ-010 The grant SHALL be held while the granted m_cyc_i is high, across any number of strobes and bursts.
REQ-011 On the granted m_cyc_i falling, the arbiter SHALL clear the grant, set last_grant to the released index and return to IDLE; no new grant SHALL issue in that same cycle (minimum 1 idle cycle between owners).
REQ-012 The watchdog counter, width $clog2(TIMEOUT+1), SHALL:
- increment each GRANT cycle with s_stb_o=1, s_ack_i=0 and s_err_i=0;
- clear on s_ack_i, on s_err_i, on s_stb_o=0, or on leaving GRANT.
REQ-013 When the counter reaches TIMEOUT, the arbiter SHALL pulse the granted m_err_o high for exactly one cycle and enter ABORT.
REQ-014 In ABORT, s_cyc_o and s_stb_o SHALL be forced to 0; the arbiter SHALL hold the grant until the granted m_cyc_i is low, then update last_grant and enter IDLE.
REQ-015 If s_ack_i or s_err_i arrives in the same cycle the counter would reach TIMEOUT, the slave response SHALL win: no abort, counter cleared.
REQ-016 If the granted master drops m_cyc_i while a slave response is pending, the release SHALL proceed per REQ-011, and a late s_ack_i SHALL NOT reach any master.
REQ-017 Requesters other than the grant holder SHALL never be starved: each waits at most NM-1 ownerships.

Reset
REQ-018 On i_reset, immediately and independent of i_clk: state=IDLE, o_grant=0, o_busy=0, counter=0, last_grant=NM-1 (master 0 served first), all m_ack_o, m_err_o, s_cyc_o and s_stb_o =0.
REQ-019 Reset mid-transaction SHALL drop s_cyc_o that same cycle; on reset release, arbitration SHALL restart from IDLE.

Structure
REQ-020 Package wb_arb_pkg SHALL hold the state enum and the default TIMEOUT constant.
REQ-021 The round-robin search SHALL be a combinational sub-module wb_arb_rr_pick (inputs: request vector and last_grant; output: one-hot next grant).

Verification
REQ-022 Master 0 alone requests, single read, slave acks 3 cycles after s_stb_o -> s_cyc_o high 1 cycle after m_cyc_i[0]; m_ack_o[0] a single cycle; m_ack_o[1]=0.
REQ-023 Both masters hold m_cyc_i continuously after reset, each releasing after 1 ack -> grant order 0,1,0,1 with exactly 1 idle cycle between owners.
REQ-024 TIMEOUT=8, slave never acks -> m_err_o[0] a single pulse on the 8th stalled cycle; s_cyc_o=0 from the next cycle until m_cyc_i[0] drops.
REQ-025 TIMEOUT=8, s_ack_i on the 8th stalled cycle -> m_ack_o asserted, m_err_o stays 0, no ABORT.
REQ-026 i_reset asserted while master 1 is in GRANT with stb pending -> s_cyc_o=0 and o_grant=0 without waiting for an edge; after release, master 0 wins when both masters request.
